// File: rtl/btn_router_pkg.sv
// rtl/btn_router_pkg.sv - shared types and helpers for the button-driven channel router
package btn_router_pkg;

    typedef enum logic [1:0] {
        DB_LO      = 2'd0,
        DB_PEND_HI = 2'd1,
        DB_HI      = 2'd2,
        DB_PEND_LO = 2'd3
    } db_state_t;

    // Counter width able to hold 0..cycles-1, never narrower than one bit.
    function automatic int cnt_w(input int cycles);
        return (cycles > 1) ? $clog2(cycles) : 1;
    endfunction

    function automatic int wrap_inc(input int idx, input int n);
        return (idx == n - 1) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/btn_debouncer.sv
// rtl/btn_debouncer.sv - button synchroniser, debounce FSM, press strobe; long-press strobe under BTN_LONGPRESS_EN
module btn_debouncer
    import btn_router_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int LONG_CYCLES     = 50_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_in,
    output logic btn_pulse,
    output logic long_pulse
);

    localparam int CNT_W = cnt_w(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       sync_q, sync_d;
    db_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             btn_pulse_q, btn_pulse_d;
    logic             s;

    assign s       = sync_q[1];
    assign sync_d  = {sync_q[0], btn_in};
    assign btn_pulse = btn_pulse_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        btn_pulse_d = 1'b0;
        case (state_q)
            DB_LO: begin
                if (s) begin
                    state_d = DB_PEND_HI;
                    cnt_d   = '0;
                end
            end
            DB_PEND_HI: begin
                if (!s) begin
                    state_d = DB_LO;
                end else if (cnt_q == CNT_LAST) begin
                    state_d     = DB_HI;
                    btn_pulse_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DB_HI: begin
                if (!s) begin
                    state_d = DB_PEND_LO;
                    cnt_d   = '0;
                end
            end
            DB_PEND_LO: begin
                if (s) begin
                    state_d = DB_HI;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = DB_LO;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = DB_LO;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q      <= '0;
            state_q     <= DB_LO;
            cnt_q       <= '0;
            btn_pulse_q <= 1'b0;
        end else begin
            sync_q      <= sync_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            btn_pulse_q <= btn_pulse_d;
        end
    end

`ifdef BTN_LONGPRESS_EN
    localparam int LP_W = cnt_w(LONG_CYCLES);
    localparam logic [LP_W-1:0] LP_LAST = LP_W'(LONG_CYCLES - 1);

    logic [LP_W-1:0] lp_cnt_q, lp_cnt_d;
    logic            lp_done_q, lp_done_d;
    logic            lp_strobe;

    // Counter saturates and the done flag survives bounces until the button is fully released.
    always_comb begin
        lp_strobe = (state_q == DB_HI) && (lp_cnt_q == LP_LAST) && !lp_done_q;
        if (state_q == DB_HI) begin
            lp_cnt_d = (lp_cnt_q == LP_LAST) ? lp_cnt_q : lp_cnt_q + 1'b1;
        end else begin
            lp_cnt_d = '0;
        end
        lp_done_d = (state_q == DB_LO) ? 1'b0 : (lp_done_q | lp_strobe);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lp_cnt_q  <= '0;
            lp_done_q <= 1'b0;
        end else begin
            lp_cnt_q  <= lp_cnt_d;
            lp_done_q <= lp_done_d;
        end
    end

    assign long_pulse = lp_strobe;
`else
    localparam int unused_long_cycles = LONG_CYCLES;
    assign long_pulse = 1'b0;
`endif

endmodule

// File: rtl/btn_channel_router.sv
// rtl/btn_channel_router.sv - routes sel to one of NUM_CH registered channels, button advances; long-press clear under BTN_LONGPRESS_EN
module btn_channel_router
    import btn_router_pkg::*;
#(
    parameter  int WIDTH           = 3,
    parameter  int NUM_CH          = 2,
    parameter  int DEBOUNCE_CYCLES = 1_000_000,
    parameter  int LONG_CYCLES     = 50_000_000,
    localparam int CH_W            = $clog2(NUM_CH)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    btn_in,
    input  logic [WIDTH-1:0]        sel,
    output logic [NUM_CH*WIDTH-1:0] ch_out,
    output logic [CH_W-1:0]         active_ch,
    output logic                    btn_pulse
);

    logic [NUM_CH*WIDTH-1:0] ch_q, ch_d;
    logic [CH_W-1:0]         active_ch_q, active_ch_d;
    logic                    long_pulse;

    btn_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .LONG_CYCLES    (LONG_CYCLES)
    ) u_debouncer (
        .clk       (clk),
        .rst       (rst),
        .btn_in    (btn_in),
        .btn_pulse (btn_pulse),
        .long_pulse(long_pulse)
    );

    // Capture on a press still lands in the old channel; the new one follows from the next cycle.
    always_comb begin
        ch_d        = ch_q;
        active_ch_d = active_ch_q;
        if (long_pulse) begin
            ch_d        = '0;
            active_ch_d = '0;
        end else begin
            ch_d[32'(active_ch_q) * WIDTH +: WIDTH] = sel;
            if (btn_pulse) begin
                active_ch_d = CH_W'(wrap_inc(32'(active_ch_q), NUM_CH));
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ch_q        <= '0;
            active_ch_q <= '0;
        end else begin
            ch_q        <= ch_d;
            active_ch_q <= active_ch_d;
        end
    end

    assign ch_out    = ch_q;
    assign active_ch = active_ch_q;

endmodule

// File: tb/tb_btn_channel_router.sv
// tb/tb_btn_channel_router.sv - self-checking bench for btn_channel_router (optionally with BTN_LONGPRESS_EN)
module tb_btn_channel_router;

    localparam int WIDTH  = 3;
    localparam int NUM_CH = 3;
    localparam int DB     = 4;
    localparam int LONG   = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn_in = 1'b0;
    logic [2:0] sel = 3'b000;
    logic [8:0] ch_out;
    logic [1:0] active_ch;
    logic       btn_pulse;

    int n_checks = 0;
    int n_fail   = 0;
    int n_pulses = 0;

    always #5 clk = ~clk;

    btn_channel_router #(
        .WIDTH          (WIDTH),
        .NUM_CH         (NUM_CH),
        .DEBOUNCE_CYCLES(DB),
        .LONG_CYCLES    (LONG)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .btn_in   (btn_in),
        .sel      (sel),
        .ch_out   (ch_out),
        .active_ch(active_ch),
        .btn_pulse(btn_pulse)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Level model: a level is accepted once the synchronised input has stayed at it for DB+1 samples.
    bit         m_sync1 = 0, m_sync2 = 0, m_lvl = 0, m_run_val = 0, m_pulse = 0, m_clr = 0;
    int         m_run = 0, m_age = 0, m_active = 0;
    logic [2:0] m_ch [NUM_CH] = '{3'b000, 3'b000, 3'b000};

    always @(posedge clk) begin
        bit s;
        s = m_sync2;
        if (rst) begin
            m_sync1 = 0; m_sync2 = 0; m_lvl = 0; m_run_val = 0; m_pulse = 0; m_clr = 0;
            m_run = 0; m_age = 0; m_active = 0;
            for (int k = 0; k < NUM_CH; k++) m_ch[k] = 3'b000;
        end else begin
            if (m_clr) begin
                for (int k = 0; k < NUM_CH; k++) m_ch[k] = 3'b000;
                m_active = 0;
            end else begin
                m_ch[m_active] = sel;
                if (m_pulse) m_active = (m_active + 1) % NUM_CH;
            end
            m_pulse = 0;
            m_clr   = 0;
            if (s == m_run_val) m_run++;
            else begin
                m_run_val = s;
                m_run = 1;
            end
            if (m_run >= DB + 1 && m_lvl != m_run_val) begin
                m_lvl   = m_run_val;
                m_pulse = m_run_val;
                m_age   = 0;
            end else if (m_lvl) begin
                m_age++;
            end
`ifdef BTN_LONGPRESS_EN
            m_clr = m_lvl && (m_age == LONG - 1);
`endif
            m_sync2 = m_sync1;
            m_sync1 = btn_in;
        end
    end

    always @(negedge clk) begin
        check("ch_out", 32'(ch_out), 32'({m_ch[2], m_ch[1], m_ch[0]}));
        check("active_ch", 32'(active_ch), 32'(m_active));
        check("btn_pulse", 32'(btn_pulse), 32'(m_pulse));
        if (btn_pulse === 1'b1) n_pulses++;
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press();
        btn_in = 1'b1;
        cyc(10);
        btn_in = 1'b0;
        cyc(10);
    endtask

    int p0;
    int pulse_at;
    int seq [3];

    initial begin
        // 1: reset
        rst = 1'b1;
        sel = 3'b101;
        @(negedge clk);
        check("t1_rst_ch", 32'(ch_out), 32'h0);
        check("t1_rst_act", 32'(active_ch), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("t1_ch0", 32'(ch_out), 32'b000_000_101);
        cyc(4);

        // 2: clean press
        p0 = n_pulses;
        pulse_at = 0;
        btn_in = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (btn_pulse === 1'b1 && pulse_at == 0) pulse_at = i;
            if (i == 8) begin
                check("t2_act", 32'(active_ch), 32'd1);
                sel = 3'b011;
            end
        end
        check("t2_pulse_edge", 32'(pulse_at), 32'd7);
        check("t2_pulse_cnt", 32'(n_pulses - p0), 32'd1);
        check("t2_ch", 32'(ch_out), 32'b000_011_101);
        btn_in = 1'b0;
        cyc(10);

        // 3: bounce
        p0 = n_pulses;
        btn_in = 1'b1; cyc(1);
        btn_in = 1'b0; cyc(1);
        btn_in = 1'b1; cyc(1);
        btn_in = 1'b0; cyc(12);
        check("t3_pulse_cnt", 32'(n_pulses - p0), 32'd0);
        check("t3_act", 32'(active_ch), 32'd1);
        check("t3_ch", 32'(ch_out), 32'b000_011_101);

        // 4: wrap
        press();
        check("t4_start_act", 32'(active_ch), 32'd2);
        p0 = n_pulses;
        for (int k = 0; k < 3; k++) begin
            sel = 3'(k + 1);
            press();
            seq[k] = 32'(active_ch);
        end
        check("t4_seq0", 32'(seq[0]), 32'd0);
        check("t4_seq1", 32'(seq[1]), 32'd1);
        check("t4_seq2", 32'(seq[2]), 32'd2);
        check("t4_pulse_cnt", 32'(n_pulses - p0), 32'd3);

        // 5: reset in the middle of a pending press, button held through it
        p0 = n_pulses;
        btn_in = 1'b1;
        cyc(4);
        rst = 1'b1;
        cyc(2);
        check("t5_rst_act", 32'(active_ch), 32'd0);
        check("t5_no_pulse", 32'(n_pulses - p0), 32'd0);
        rst = 1'b0;
        pulse_at = 0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (btn_pulse === 1'b1 && pulse_at == 0) pulse_at = i;
        end
        check("t5_pulse_edge", 32'(pulse_at), 32'd7);
        check("t5_act", 32'(active_ch), 32'd1);
        btn_in = 1'b0;
        cyc(10);

        // 6: long hold
        sel = 3'b110;
        p0 = n_pulses;
        btn_in = 1'b1;
        cyc(30);
        check("t6_pulse_cnt", 32'(n_pulses - p0), 32'd1);
`ifdef BTN_LONGPRESS_EN
        check("t6_act", 32'(active_ch), 32'd0);
        check("t6_ch21", 32'(ch_out[8:3]), 32'd0);
        check("t6_ch0", 32'(ch_out[2:0]), 32'b110);
`else
        check("t6_act", 32'(active_ch), 32'd2);
        check("t6_ch2", 32'(ch_out[8:6]), 32'b110);
`endif
        btn_in = 1'b0;
        cyc(10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
